mult_pipe: RTL and testbench
============================

MULT_PIPE -- requirements
Module: mult_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits.
REQ-002 SHALL have parameter LATENCY, default 3, register stages from operand capture to product output; legal range 2..4.
REQ-003 SHALL have port clk, input, 1 bit, single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port a, input, WIDTH bits, unsigned multiplicand.
REQ-006 SHALL have port b, input, WIDTH bits, unsigned multiplier.
REQ-007 SHALL have port p, output, 2*WIDTH bits, registered unsigned product.

Function
REQ-008 SHALL compute p = a * b, both operands unsigned, with the full 2*WIDTH-bit result and no truncation, rounding or saturation.
REQ-009 SHALL sample a and b on every rising edge with no enable, valid or handshake.
REQ-010 SHALL present the product of operands sampled at edge k on p immediately after edge k+LATENCY-1.
- For LATENCY=3, capture occurs at edges k, k+1 and k+2.
- The MAC caller counts this latency itself.
REQ-011 SHALL sustain a throughput of one product per clock, with independent back-to-back operands and no bubbles or stalls.
REQ-012 SHALL hold p constant between edges, driven directly from a register with no combinational path from a or b to p.
REQ-013 SHALL use the following datapath for LATENCY=3:
- Stage 1 registers a and b.
- Stage 2 splits each operand into WIDTH/2-bit halves and registers the four partial products: lo*lo, lo*hi, hi*lo and hi*hi.
- Stage 3 registers the shifted sum: hh<<WIDTH + (lh+hl)<<(WIDTH/2) + ll.
REQ-014 SHALL handle other LATENCY values as follows:
- LATENCY=2 merges stages 2 and 3.
- LATENCY=4 adds one output register after stage 3.
REQ-015 SHALL give correct results at the extremes: 0*x = 0, and (2^WIDTH-1)^2 = 0xFFFE0001 for WIDTH=16 without overflow.
REQ-016 SHALL require WIDTH to be even.
REQ-017 SHALL contain no state machine; the block is a pure shift pipeline.

Reset
REQ-018 SHALL, while rst=1, asynchronously clear every pipeline register, including p, to 0.
REQ-019 SHALL, after rst deasserts, output p=0 until the first operands sampled after release reach the output LATENCY-1 edges later.
REQ-020 SHALL discard any operands in flight when rst asserts mid-operation; they never appear on p.

Structure
REQ-021 SHALL hold the WIDTH and LATENCY defaults in the shared package mult_pkg, together with constants HALF=WIDTH/2 and PWIDTH=2*WIDTH.
REQ-022 SHALL implement the HALF x HALF unsigned partial-product multiplier as one sub-module, mult_half, instantiated four times in stage 2.
- The top level contains only the pipeline registers and the final adder.

Verification
REQ-023 SHALL cover single operation: after reset, a=3, b=5 at edge 0, then a=b=0 -> p=15 after edge 2, and p=0 after edge 3.
REQ-024 SHALL cover back-to-back streaming: (1,1), (2,3), (0xFFFF,0xFFFF), (0x1234,0x0010) at edges 0..3 -> p=1, 6, 0xFFFE0001, 0x00012340 after edges 2..5 respectively.
REQ-025 SHALL cover zero and identity: (0,0xFFFF) -> 0, and (0xABCD,1) -> 0x0000ABCD.
REQ-026 SHALL cover mid-stream reset: stream nonzero products, assert rst asynchronously between edges -> p=0 immediately; after release with a=b=0 -> p stays 0.
REQ-027 SHALL cover a random regression: 10,000 random operand pairs, each compared against a reference a*b delayed by LATENCY-1 edges; run at LATENCY=2, 3 and 4.

Source files
------------

// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared constants for the pipelined unsigned multiplier.
//   DEF_WIDTH   : default operand width in bits (must be even)
//   DEF_LATENCY : default number of register stages, operand capture to p
//   HALF        : width of one operand half at the default width
//   PWIDTH      : full product width at the default width
// ---------------------------------------------------------------------------
package mult_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_LATENCY = 3;
    localparam int HALF        = DEF_WIDTH / 2;
    localparam int PWIDTH      = 2 * DEF_WIDTH;

endpackage

// File: rtl/mult_half.sv
// ---------------------------------------------------------------------------
// mult_half
// Purely combinational HW x HW unsigned multiplier used for one partial
// product of the split-operand datapath.
//   i_a : HW-bit unsigned operand
//   i_b : HW-bit unsigned operand
//   o_p : 2*HW-bit unsigned product, never truncated
// ---------------------------------------------------------------------------
module mult_half
    import mult_pkg::*;
#(
    parameter int HW = HALF
) (
    input  logic [HW-1:0]   i_a,
    input  logic [HW-1:0]   i_b,
    output logic [2*HW-1:0] o_p
);

    // Zero-extend both operands first so the product is computed at the
    // full output width rather than at the operand width.
    assign o_p = {{HW{1'b0}}, i_a} * {{HW{1'b0}}, i_b};

endmodule

// File: rtl/mult_pipe.sv
// ---------------------------------------------------------------------------
// mult_pipe
// Fully pipelined unsigned WIDTH x WIDTH multiplier, one product per clock.
// Operands sampled at edge k appear on p just after edge k+LATENCY-1.
//   clk : single clock, rising edge
//   rst : asynchronous active-high reset, clears every stage including p
//   a   : WIDTH-bit unsigned multiplicand
//   b   : WIDTH-bit unsigned multiplier
//   p   : 2*WIDTH-bit registered unsigned product
// Stages: operand registers, four registered half-width partial products,
// registered shifted sum, and an optional extra output register.
// LATENCY=2 drops the partial-product registers, LATENCY=4 adds the extra
// output register.
// ---------------------------------------------------------------------------
module mult_pipe
    import mult_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);

    localparam int HW = WIDTH / 2;
    localparam int PW = 2 * WIDTH;

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
        $error("mult_pipe: WIDTH must be even and at least 4");
    end
    if (LATENCY < 2 || LATENCY > 4) begin : g_bad_latency
        $error("mult_pipe: LATENCY must be 2, 3 or 4");
    end

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
        end else begin
            r_a <= a;
            r_b <= b;
        end
    end

    logic [WIDTH-1:0] w_ll;
    logic [WIDTH-1:0] w_lh;
    logic [WIDTH-1:0] w_hl;
    logic [WIDTH-1:0] w_hh;

    mult_half #(.HW(HW)) u_ll (.i_a(r_a[HW-1:0]),     .i_b(r_b[HW-1:0]),     .o_p(w_ll));
    mult_half #(.HW(HW)) u_lh (.i_a(r_a[HW-1:0]),     .i_b(r_b[WIDTH-1:HW]), .o_p(w_lh));
    mult_half #(.HW(HW)) u_hl (.i_a(r_a[WIDTH-1:HW]), .i_b(r_b[HW-1:0]),     .o_p(w_hl));
    mult_half #(.HW(HW)) u_hh (.i_a(r_a[WIDTH-1:HW]), .i_b(r_b[WIDTH-1:HW]), .o_p(w_hh));

    // Partial products feeding the final adder: taken straight from the
    // half multipliers when stages 2 and 3 are merged, otherwise registered.
    logic [WIDTH-1:0] w_sll;
    logic [WIDTH-1:0] w_slh;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shh;

    if (LATENCY == 2) begin : g_merged
        assign w_sll = w_ll;
        assign w_slh = w_lh;
        assign w_shl = w_hl;
        assign w_shh = w_hh;
    end else begin : g_pp_regs
        logic [WIDTH-1:0] r_ll;
        logic [WIDTH-1:0] r_lh;
        logic [WIDTH-1:0] r_hl;
        logic [WIDTH-1:0] r_hh;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_ll <= '0;
                r_lh <= '0;
                r_hl <= '0;
                r_hh <= '0;
            end else begin
                r_ll <= w_ll;
                r_lh <= w_lh;
                r_hl <= w_hl;
                r_hh <= w_hh;
            end
        end

        assign w_sll = r_ll;
        assign w_slh = r_lh;
        assign w_shl = r_hl;
        assign w_shh = r_hh;
    end

    // The two cross terms can carry one bit beyond WIDTH, so they are summed
    // at WIDTH+1 bits before being placed HW bits up in the product.
    logic [WIDTH:0] w_cross;
    logic [PW-1:0]  w_sum;

    assign w_cross = {1'b0, w_slh} + {1'b0, w_shl};
    assign w_sum   = {w_shh, {WIDTH{1'b0}}}
                   + {{(HW-1){1'b0}}, w_cross, {HW{1'b0}}}
                   + {{WIDTH{1'b0}}, w_sll};

    logic [PW-1:0] r_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
        end else begin
            r_sum <= w_sum;
        end
    end

    if (LATENCY == 4) begin : g_out_reg
        logic [PW-1:0] r_out;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_out <= '0;
            end else begin
                r_out <= r_sum;
            end
        end

        assign p = r_out;
    end else begin : g_no_out_reg
        assign p = r_sum;
    end

endmodule

// File: tb/tb_mult_pipe.sv
// ---------------------------------------------------------------------------
// tb_mult_pipe
// Three multipliers (LATENCY 2, 3 and 4) share one operand stream. Each
// issued operand pair pushes its plain-arithmetic product into one queue per
// instance; a monitor pops the queue once the instance's latency has elapsed
// and compares against p every cycle.
// ---------------------------------------------------------------------------
module tb_mult_pipe;
    import mult_pkg::*;

    localparam int W = DEF_WIDTH;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [W-1:0]      a   = '0;
    logic [W-1:0]      b   = '0;
    logic [PWIDTH-1:0] p2;
    logic [PWIDTH-1:0] p3;
    logic [PWIDTH-1:0] p4;

    int nVectors = 0;
    int nFails   = 0;

    logic [PWIDTH-1:0] q2 [$];
    logic [PWIDTH-1:0] q3 [$];
    logic [PWIDTH-1:0] q4 [$];

    // Directed sequence after reset release with the expected LATENCY=3
    // output just after each edge.
    logic [W-1:0]      dirA    [12] = '{16'h0003, 16'h0000, 16'h0000, 16'h0001,
                                        16'h0002, 16'hFFFF, 16'h1234, 16'h0000,
                                        16'hABCD, 16'h0000, 16'h0000, 16'h0000};
    logic [W-1:0]      dirB    [12] = '{16'h0005, 16'h0000, 16'h0000, 16'h0001,
                                        16'h0003, 16'hFFFF, 16'h0010, 16'hFFFF,
                                        16'h0001, 16'h0000, 16'h0000, 16'h0000};
    logic [PWIDTH-1:0] dirExp3 [12] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_000F, 32'h0000_0000,
                                        32'h0000_0000, 32'h0000_0001, 32'h0000_0006, 32'hFFFE_0001,
                                        32'h0001_2340, 32'h0000_0000, 32'h0000_ABCD, 32'h0000_0000};

    always #5 clk = ~clk;

    mult_pipe #(.WIDTH(W), .LATENCY(2)) u_lat2 (.clk(clk), .rst(rst), .a(a), .b(b), .p(p2));
    mult_pipe #(.WIDTH(W), .LATENCY(3)) u_lat3 (.clk(clk), .rst(rst), .a(a), .b(b), .p(p3));
    mult_pipe #(.WIDTH(W), .LATENCY(4)) u_lat4 (.clk(clk), .rst(rst), .a(a), .b(b), .p(p4));

    // One comparison: counts it and reports a miscompare.
    task automatic checkOutput(input string name, input logic [PWIDTH-1:0] actual,
                               input logic [PWIDTH-1:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h",
                     name, $time, actual, expected);
        end
    endtask

    // Reference model: the full-width unsigned product, one entry per edge.
    task automatic pushExpected(input logic [W-1:0] va, input logic [W-1:0] vb);
        logic [PWIDTH-1:0] prod;
        prod = PWIDTH'(va) * PWIDTH'(vb);
        q2.push_back(prod);
        q3.push_back(prod);
        q4.push_back(prod);
    endtask

    // Drives one operand pair away from the rising edge; it is sampled at
    // the next rising edge.
    task automatic applyStimulus(input logic [W-1:0] va, input logic [W-1:0] vb);
        @(negedge clk);
        a = va;
        b = vb;
        pushExpected(va, vb);
    endtask

    task automatic stepAndCheck(input logic [W-1:0] va, input logic [W-1:0] vb,
                                input logic [PWIDTH-1:0] exp3, input string name);
        applyStimulus(va, vb);
        @(posedge clk);
        #2;
        checkOutput(name, p3, exp3);
    endtask

    // Asserts reset between edges and confirms p clears without a clock.
    task automatic assertReset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_clear_lat2", p2, '0);
        checkOutput("async_clear_lat3", p3, '0);
        checkOutput("async_clear_lat4", p4, '0);
        q2.delete();
        q3.delete();
        q4.delete();
    endtask

    // Releases reset between edges; the next edge samples a=b=0.
    task automatic releaseReset();
        @(negedge clk);
        rst = 1'b0;
        a   = '0;
        b   = '0;
        pushExpected('0, '0);
    endtask

    // Monitor: after every edge, each instance shows the product issued
    // LATENCY-1 edges earlier, or zero while that much history is missing.
    always @(posedge clk) begin
        logic [PWIDTH-1:0] e2;
        logic [PWIDTH-1:0] e3;
        logic [PWIDTH-1:0] e4;
        #2;
        if (rst) begin
            checkOutput("reset_lat2", p2, '0);
            checkOutput("reset_lat3", p3, '0);
            checkOutput("reset_lat4", p4, '0);
        end else begin
            e2 = '0;
            e3 = '0;
            e4 = '0;
            if (q2.size() >= 2) e2 = q2.pop_front();
            if (q3.size() >= 3) e3 = q3.pop_front();
            if (q4.size() >= 4) e4 = q4.pop_front();
            checkOutput("stream_lat2", p2, e2);
            checkOutput("stream_lat3", p3, e3);
            checkOutput("stream_lat4", p4, e4);
        end
    end

    // Watchdog against a stalled run.
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        $display("[TB] starting mult_pipe regression");
        repeat (3) @(negedge clk);
        releaseReset();

        for (int i = 0; i < 12; i++) begin
            stepAndCheck(dirA[i], dirB[i], dirExp3[i], $sformatf("directed_%0d", i));
        end

        // Nonzero stream, then a reset in the middle of it.
        for (int i = 0; i < 6; i++) begin
            ra = W'($urandom_range(1, 65535));
            rb = W'($urandom_range(1, 65535));
            applyStimulus(ra, rb);
        end
        assertReset();
        repeat (2) @(negedge clk);
        releaseReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus('0, '0);
        end

        // Random regression with occasional extreme operands.
        for (int i = 0; i < 10000; i++) begin
            ra = W'($urandom());
            rb = W'($urandom());
            case (i % 32)
                5:  ra = '0;
                11: rb = '1;
                17: begin ra = '1; rb = '1; end
                23: rb = 16'h0001;
                default: ;
            endcase
            applyStimulus(ra, rb);
        end

        for (int i = 0; i < 5; i++) begin
            applyStimulus('0, '0);
        end
        @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFails);
        $finish;
    end

endmodule
